// File: rtl/ocl_bcast_seq_pkg.sv
// ocl_bcast_seq_pkg: shared types and constants for the OCL broadcast sequencer
package ocl_bcast_seq_pkg;
  localparam logic [7:0] BCAST_TILE      = 8'hFF;
  localparam logic [1:0] OCL_RESP_SLVERR = 2'b10;
  typedef logic [31:0] reg_data_t;
  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_RESP} ocl_seq_state_t;
endpackage

// File: rtl/ocl_seq_timeout.sv
// ocl_seq_timeout: clear/enable wait counter with a terminal-count pulse
module ocl_seq_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + TW'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign tc = en && cnt_q == TW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/ocl_bcast_seq.sv
// ocl_bcast_seq: routes host OCL requests to one tile or replays them across all tiles
module ocl_bcast_seq
  import ocl_bcast_seq_pkg::*;
#(
  parameter int N_TILES        = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         n_tiles,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_err,
  output logic [31:0]        resp_rdata,
  output logic [N_TILES-1:0] tile_awvalid,
  input  logic [N_TILES-1:0] tile_awready,
  output logic [N_TILES-1:0] tile_wvalid,
  input  logic [N_TILES-1:0] tile_wready,
  output logic [31:0]        tile_addr,
  output logic [31:0]        tile_wdata,
  input  logic [N_TILES-1:0] tile_bvalid,
  output logic [N_TILES-1:0] tile_bready,
  output logic [N_TILES-1:0] tile_arvalid,
  input  logic [N_TILES-1:0] tile_arready,
  input  logic [N_TILES-1:0] tile_rvalid,
  input  reg_data_t          tile_rdata [N_TILES],
  output logic [N_TILES-1:0] tile_rready
);
  localparam int CW = N_TILES > 1 ? $clog2(N_TILES) : 1;
  ocl_seq_state_t state_q, state_d;
  logic [CW-1:0] cur_q, cur_d;
  logic [7:0] cnt_q, cnt_d, id, clamp;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, acc_q, acc_d;
  logic wr_q, wr_d, bc_q, bc_d, err_q, err_d, pend_q, pend_d;
  logic [N_TILES-1:0] sel;
  logic wait_st, hs, tc, adv, last, clr;
  assign id      = req_addr[23:16];
  assign clamp   = n_tiles > 8'(N_TILES) ? 8'(N_TILES) : n_tiles;
  assign sel     = N_TILES'(1) << cur_q;
  assign wait_st = state_q inside {S_AW, S_W, S_B, S_AR, S_R};
  assign hs      = state_q == S_AW ? tile_awready[cur_q] :
                   state_q == S_W  ? tile_wready[cur_q]  :
                   state_q == S_B  ? tile_bvalid[cur_q]  :
                   state_q == S_AR ? tile_arready[cur_q] :
                   state_q == S_R && tile_rvalid[cur_q];
  // a handshake on the terminal cycle wins over the timeout
  assign adv  = (hs && (state_q == S_B || state_q == S_R)) || (tc && !hs);
  assign last = !bc_q || 8'(cur_q) + 8'd1 == cnt_q;
  assign clr  = adv || state_d != state_q;
  ocl_seq_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk(clk), .rst(rst), .clr(clr), .en(wait_st), .tc(tc)
  );
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    acc_d   = acc_q;
    wr_d    = wr_q;
    bc_d    = bc_q;
    err_d   = err_q;
    pend_d  = 1'b0;
    case (state_q)
      S_IDLE:
        if (pend_q) state_d = S_RESP;
        else if (req_valid && req_ready) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wr_d    = req_write;
          cnt_d   = clamp;
          bc_d    = id == BCAST_TILE;
          acc_d   = '0;
          err_d   = 1'b0;
          if (id == BCAST_TILE) begin
            cur_d   = '0;
            state_d = clamp == 8'd0 ? S_RESP : req_write ? S_AW : S_AR;
          end else if (id < clamp) begin
            cur_d   = req_addr[16 +: CW];
            state_d = req_write ? S_AW : S_AR;
          end else begin
            err_d  = 1'b1;
            pend_d = 1'b1;
          end
        end
      S_AW:   if (hs) state_d = S_W;
      S_W:    if (hs) state_d = S_B;
      S_AR:   if (hs) state_d = S_R;
      S_R:    if (hs) acc_d = acc_q + tile_rdata[cur_q];
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: ;
    endcase
    if (adv) begin
      err_d = err_q | !hs;
      if (last) state_d = S_RESP;
      else begin
        cur_d   = cur_q + CW'(1);
        state_d = wr_q ? S_AW : S_AR;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      acc_q   <= '0;
      wr_q    <= 1'b0;
      bc_q    <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      acc_q   <= acc_d;
      wr_q    <= wr_d;
      bc_q    <= bc_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end
  // non-current tiles always drain responses so late replies from abandoned tiles vanish
  assign req_ready    = !rst && state_q == S_IDLE && !pend_q;
  assign resp_valid   = !rst && state_q == S_RESP;
  assign resp_err     = resp_valid && err_q;
  assign resp_rdata   = resp_valid && !wr_q ? acc_q : '0;
  assign tile_awvalid = !rst && state_q == S_AW ? sel : '0;
  assign tile_wvalid  = !rst && state_q == S_W  ? sel : '0;
  assign tile_arvalid = !rst && state_q == S_AR ? sel : '0;
  assign tile_bready  = ~sel | (state_q == S_B ? sel : '0);
  assign tile_rready  = ~sel | (state_q == S_R ? sel : '0);
  assign tile_addr    = rst ? '0 : addr_q;
  assign tile_wdata   = rst ? '0 : wdata_q;
endmodule

// File: tb/tb_ocl_bcast_seq.sv
// tb_ocl_bcast_seq: directed and randomized checks of the OCL broadcast sequencer
module tb_ocl_bcast_seq;
  import ocl_bcast_seq_pkg::*;
  localparam int N = 8;
  localparam int T = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] n_tiles;
  logic req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata, tile_addr, tile_wdata;
  logic [N-1:0] tile_awvalid, tile_awready, tile_wvalid, tile_wready, tile_bvalid, tile_bready;
  logic [N-1:0] tile_arvalid, tile_arready, tile_rvalid, tile_rready;
  reg_data_t tile_rdata [N];
  logic [N-1:0] dead_aw, dead_w, dead_b, dead_ar, dead_r, b_inj;
  logic [N-1:0] rdy = '1, b_pend = '0, r_pend = '0, prev_av = '0;
  logic rand_on = 1'b0, proto_bad = 1'b0;
  int log_q[$];
  logic [31:0] alog[$], dlog[$];
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  ocl_bcast_seq #(.N_TILES(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .n_tiles(n_tiles), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .tile_awvalid(tile_awvalid), .tile_awready(tile_awready), .tile_wvalid(tile_wvalid),
    .tile_wready(tile_wready), .tile_addr(tile_addr), .tile_wdata(tile_wdata),
    .tile_bvalid(tile_bvalid), .tile_bready(tile_bready), .tile_arvalid(tile_arvalid),
    .tile_arready(tile_arready), .tile_rvalid(tile_rvalid), .tile_rdata(tile_rdata),
    .tile_rready(tile_rready)
  );

  // behavioural tiles: dead channels never handshake, pending responses wait for ready
  assign tile_awready = ~dead_aw & rdy;
  assign tile_wready  = ~dead_w & rdy;
  assign tile_arready = ~dead_ar & rdy;
  assign tile_bvalid  = (b_pend & rdy) | b_inj;
  assign tile_rvalid  = r_pend & rdy;

  always @(negedge clk)
    for (int i = 0; i < N; i++) rdy[i] <= !rand_on || $urandom_range(3) != 0;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (tile_wvalid[i] && tile_wready[i] && !dead_b[i]) b_pend[i] <= 1'b1;
      else if (tile_bvalid[i] && tile_bready[i]) b_pend[i] <= 1'b0;
      if (tile_arvalid[i] && tile_arready[i] && !dead_r[i]) r_pend[i] <= 1'b1;
      else if (tile_rvalid[i] && tile_rready[i]) r_pend[i] <= 1'b0;
    end
    if ((tile_awvalid | tile_arvalid) != prev_av && (tile_awvalid | tile_arvalid) != '0) begin
      for (int i = 0; i < N; i++) if (tile_awvalid[i] || tile_arvalid[i]) log_q.push_back(i);
      alog.push_back(tile_addr);
      dlog.push_back(tile_wdata);
    end
    if (!$onehot0(tile_awvalid | tile_wvalid | tile_arvalid)) proto_bad <= 1'b1;
    prev_av <= tile_awvalid | tile_arvalid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference: visit list, error and wrapped sum derived from the request rules
  task automatic run(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [7:0] nt, input int exp_lat);
    int q[$];
    int cnt, id, lat, g;
    logic [31:0] sum;
    logic er;
    cnt = nt > N ? N : int'(nt);
    id  = int'(addr[23:16]);
    sum = 0;
    er  = 1'b0;
    if (id == 255) for (int t = 0; t < cnt; t++) q.push_back(t);
    else if (id < cnt) q.push_back(id);
    else er = 1'b1;
    foreach (q[k])
      if (wr ? (dead_aw[q[k]] | dead_w[q[k]] | dead_b[q[k]]) : (dead_ar[q[k]] | dead_r[q[k]])) er = 1'b1;
      else if (!wr) sum += tile_rdata[q[k]];
    log_q.delete();
    alog.delete();
    dlog.delete();
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; n_tiles = nt;
    g = 0;
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    chk("accept", 32'(g < 50), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 1000);
    chk("resp_valid", 32'(resp_valid), 1);
    if (exp_lat > 0) chk("latency", lat, exp_lat);
    repeat ($urandom_range(2)) @(negedge clk);
    chk("rdata", resp_rdata, sum);
    chk("err", 32'(resp_err), 32'(er));
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("visit_count", log_q.size(), q.size());
    foreach (q[k]) if (k < log_q.size()) chk("visit_order", log_q[k], q[k]);
    foreach (alog[k]) chk("tile_addr", alog[k], addr);
    if (wr) foreach (dlog[k]) chk("tile_wdata", dlog[k], wd);
    chk("protocol", 32'(proto_bad), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    logic [7:0] rid;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; n_tiles = 8; resp_ready = 0;
    dead_aw = 0; dead_w = 0; dead_b = 0; dead_ar = 0; dead_r = 0; b_inj = 0;
    for (int i = 0; i < N; i++) tile_rdata[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_valids", 32'({tile_awvalid, tile_wvalid, tile_arvalid}), 0);
    chk("rst_tile_addr", tile_addr, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 1);

    run(1'b1, 32'h0003_0010, 32'hA5A5_0001, 8'd8, 4);
    run(1'b0, 32'h0006_0004, 0, 8'd8, 3);
    for (int i = 0; i < N; i++) tile_rdata[i] = 32'(i + 1);
    run(1'b0, 32'h00FF_0020, 0, 8'd4, 9);
    tile_rdata[0] = 32'h8000_0001; tile_rdata[1] = 32'h8000_0001;
    run(1'b0, 32'h00FF_0020, 0, 8'd2, 5);
    run(1'b1, 32'h0005_0000, 32'h1, 8'd4, 2);
    run(1'b0, 32'h00FF_0000, 0, 8'd0, 1);
    run(1'b0, 32'h00FF_0008, 0, 8'd200, 0);

    dead_w[1] = 1'b1;
    run(1'b1, 32'h00FF_0040, 32'hDEAD_0002, 8'd3, 24);
    dead_w = 0;
    @(negedge clk);
    b_inj[1] = 1'b1;
    chk("drain_bready", 32'(tile_bready[1]), 1);
    @(negedge clk);
    b_inj = 0;
    chk("drain_no_resp", 32'(resp_valid), 0);
    chk("drain_idle", 32'(req_ready), 1);

    for (int i = 0; i < N; i++) tile_rdata[i] = 32'(i + 1);
    dead_r[2] = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h00FF_0000; n_tiles = 8'd4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    g = 0;
    while (!tile_arvalid[2] && g < 100) begin @(negedge clk); g++; end
    chk("reach_tile2", 32'(g < 100), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valids", 32'({tile_awvalid, tile_wvalid, tile_arvalid}), 0);
    chk("midrst_resp_valid", 32'(resp_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    dead_r = 0;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 1);
    run(1'b0, 32'h00FF_0000, 0, 8'd4, 9);

    rand_on = 1'b1;
    repeat (60) begin
      dead_aw = 0; dead_w = 0; dead_b = 0; dead_ar = 0; dead_r = 0;
      if ($urandom_range(4) == 0)
        case ($urandom_range(4))
          0: dead_aw[$urandom_range(N - 1)] = 1'b1;
          1: dead_w[$urandom_range(N - 1)] = 1'b1;
          2: dead_b[$urandom_range(N - 1)] = 1'b1;
          3: dead_ar[$urandom_range(N - 1)] = 1'b1;
          default: dead_r[$urandom_range(N - 1)] = 1'b1;
        endcase
      for (int i = 0; i < N; i++) tile_rdata[i] = $urandom;
      rid = $urandom_range(3) == 0 ? 8'hFF : 8'($urandom_range(9));
      run(1'($urandom_range(1)), {8'($urandom), rid, 16'($urandom)}, $urandom, 8'($urandom_range(10)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
